// File: rtl/bmm150_reader.sv
// BMM150 bring-up and periodic sampling sequencer: the only source of commands for the SPI master.
// Powers the sensor, verifies the chip ID, selects normal mode, then burst-reads and publishes samples.
module bmm150_reader #(
   parameter int CLK_HZ      = 50_000_000,
   parameter int STARTUP_US  = 3000,
   parameter int SAMPLE_HZ   = 10,
   parameter int TXN_TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   output logic        spi_start,
   output logic        spi_rw,
   output logic [6:0]  spi_reg_addr,
   output logic [7:0]  spi_tx_data,
   input  logic [7:0]  spi_rx_data,
   input  logic        spi_busy,
   input  logic        spi_done,
   output logic [12:0] mag_x,
   output logic [12:0] mag_y,
   output logic [14:0] mag_z,
   output logic [13:0] rhall,
   output logic        sample_valid,
   output logic        init_done,
   output logic        err_id,
   output logic        err_timeout
);

   localparam int STARTUP_CYC = CLK_HZ / 1_000_000 * STARTUP_US;
   localparam int PERIOD_CYC  = CLK_HZ / SAMPLE_HZ;
   localparam int SW = $clog2(STARTUP_CYC + 1);
   localparam int PW = $clog2(PERIOD_CYC + 1);
   localparam int TW = $clog2(TXN_TIMEOUT + 1);
   localparam logic [SW-1:0] STARTUP_LAST = SW'(STARTUP_CYC - 1);
   localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CYC - 1);
   localparam logic [TW-1:0] TMO_LAST     = TW'(TXN_TIMEOUT - 1);

   typedef enum logic [2:0] {
      PWR_ON, PWR_WAIT, READ_ID, SET_MODE, WAIT_PERIOD, BURST, PUBLISH, FAULT
   } state_t;

   state_t        state_q, state_d;
   logic          txnWait_q, txnWait_d;
   logic          armed_q;
   logic [SW-1:0] startCnt_q, startCnt_d;
   logic [PW-1:0] periodCnt_q, periodCnt_d;
   logic          periodRun_q, periodRun_d;
   logic          firstBurst_q, firstBurst_d;
   logic          pending_q, pending_d;
   logic [TW-1:0] tmoCnt_q, tmoCnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    buf_q [8];
   logic [7:0]    buf_d [8];
   logic [12:0]   magX_q, magX_d, magY_q, magY_d;
   logic [14:0]   magZ_q, magZ_d;
   logic [13:0]   rhall_q, rhall_d;
   logic          sampleValid_q, sampleValid_d;
   logic          initDone_q, initDone_d;
   logic          errId_q, errId_d;
   logic          errTimeout_q, errTimeout_d;

   logic          isTxn, periodTick, reqRw;
   logic [6:0]    reqAddr;
   logic [7:0]    reqTx;

   always_comb begin
      state_d       = state_q;
      txnWait_d     = txnWait_q;
      startCnt_d    = startCnt_q;
      periodCnt_d   = periodCnt_q;
      periodRun_d   = periodRun_q;
      firstBurst_d  = firstBurst_q;
      pending_d     = pending_q;
      tmoCnt_d      = tmoCnt_q;
      idx_d         = idx_q;
      buf_d         = buf_q;
      magX_d        = magX_q;
      magY_d        = magY_q;
      magZ_d        = magZ_q;
      rhall_d       = rhall_q;
      sampleValid_d = 1'b0;
      initDone_d    = initDone_q;
      errId_d       = errId_q;
      errTimeout_d  = errTimeout_q;
      spi_start     = 1'b0;
      spi_rw        = 1'b0;
      spi_reg_addr  = 7'h00;
      spi_tx_data   = 8'h00;
      reqRw         = 1'b0;
      reqAddr       = 7'h00;
      reqTx         = 8'h00;
      isTxn = (state_q == PWR_ON) || (state_q == READ_ID) ||
              (state_q == SET_MODE) || (state_q == BURST);

      // A tick that lands outside WAIT_PERIOD is remembered so an overrunning burst is followed at once
      periodTick = periodRun_q && enable && (periodCnt_q == PERIOD_LAST);
      if (periodRun_q && enable)
         periodCnt_d = periodTick ? '0 : periodCnt_q + 1'b1;
      if (periodTick && (state_q != WAIT_PERIOD))
         pending_d = 1'b1;

      case (state_q)
         PWR_ON:   begin reqRw = 1'b0; reqAddr = 7'h4B; reqTx = 8'h01; end
         READ_ID:  begin reqRw = 1'b1; reqAddr = 7'h40; end
         SET_MODE: begin reqRw = 1'b0; reqAddr = 7'h4C; reqTx = 8'h00; end
         BURST:    begin reqRw = 1'b1; reqAddr = 7'h42 + {4'b0000, idx_q}; end
         default:  ;
      endcase

      if (isTxn) begin
         if (!txnWait_q) begin
            if (rst_n && armed_q && enable && !spi_busy && !spi_done) begin
               spi_start = 1'b1;
               txnWait_d = 1'b1;
               tmoCnt_d  = TW'(1);
            end
         end else if (spi_done) begin
            txnWait_d = 1'b0;
            case (state_q)
               PWR_ON: begin
                  state_d    = PWR_WAIT;
                  startCnt_d = '0;
               end
               READ_ID: begin
                  if (spi_rx_data == 8'h32) begin
                     state_d = SET_MODE;
                  end else begin
                     errId_d = 1'b1;
                     state_d = FAULT;
                  end
               end
               SET_MODE: begin
                  initDone_d   = 1'b1;
                  periodCnt_d  = '0;
                  periodRun_d  = 1'b0;
                  firstBurst_d = 1'b1;
                  pending_d    = 1'b0;
                  state_d      = WAIT_PERIOD;
               end
               default: begin
                  buf_d[idx_q] = spi_rx_data;
                  if (idx_q == 3'd7) begin
                     idx_d   = 3'd0;
                     state_d = PUBLISH;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end
            endcase
         end else if (tmoCnt_q == TMO_LAST) begin
            txnWait_d    = 1'b0;
            errTimeout_d = 1'b1;
            state_d      = FAULT;
         end else begin
            tmoCnt_d = tmoCnt_q + 1'b1;
         end
      end

      // Command fields are only presented while a transaction is being issued or awaited
      if (spi_start || txnWait_q) begin
         spi_rw       = reqRw;
         spi_reg_addr = reqAddr;
         spi_tx_data  = reqTx;
      end

      case (state_q)
         PWR_WAIT: begin
            if (startCnt_q == STARTUP_LAST) begin
               startCnt_d = '0;
               state_d    = READ_ID;
            end else begin
               startCnt_d = startCnt_q + 1'b1;
            end
         end
         WAIT_PERIOD: begin
            if (firstBurst_q || pending_q || periodTick) begin
               firstBurst_d = 1'b0;
               pending_d    = 1'b0;
               periodRun_d  = 1'b1;
               state_d      = BURST;
            end
         end
         PUBLISH: begin
            if (buf_q[6][0]) begin
               magX_d        = {buf_q[1], buf_q[0][7:3]};
               magY_d        = {buf_q[3], buf_q[2][7:3]};
               magZ_d        = {buf_q[5], buf_q[4][7:1]};
               rhall_d       = {buf_q[7], buf_q[6][7:2]};
               sampleValid_d = 1'b1;
            end
            state_d = WAIT_PERIOD;
         end
         default: ;
      endcase
   end

   // armed_q keeps spi_start low in the first cycle after reset is released
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= PWR_ON;
         txnWait_q     <= 1'b0;
         armed_q       <= 1'b0;
         startCnt_q    <= '0;
         periodCnt_q   <= '0;
         periodRun_q   <= 1'b0;
         firstBurst_q  <= 1'b0;
         pending_q     <= 1'b0;
         tmoCnt_q      <= '0;
         idx_q         <= 3'd0;
         buf_q         <= '{default: 8'h00};
         magX_q        <= '0;
         magY_q        <= '0;
         magZ_q        <= '0;
         rhall_q       <= '0;
         sampleValid_q <= 1'b0;
         initDone_q    <= 1'b0;
         errId_q       <= 1'b0;
         errTimeout_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         txnWait_q     <= txnWait_d;
         armed_q       <= 1'b1;
         startCnt_q    <= startCnt_d;
         periodCnt_q   <= periodCnt_d;
         periodRun_q   <= periodRun_d;
         firstBurst_q  <= firstBurst_d;
         pending_q     <= pending_d;
         tmoCnt_q      <= tmoCnt_d;
         idx_q         <= idx_d;
         buf_q         <= buf_d;
         magX_q        <= magX_d;
         magY_q        <= magY_d;
         magZ_q        <= magZ_d;
         rhall_q       <= rhall_d;
         sampleValid_q <= sampleValid_d;
         initDone_q    <= initDone_d;
         errId_q       <= errId_d;
         errTimeout_q  <= errTimeout_d;
      end
   end

   assign mag_x        = magX_q;
   assign mag_y        = magY_q;
   assign mag_z        = magZ_q;
   assign rhall        = rhall_q;
   assign sample_valid = sampleValid_q;
   assign init_done    = initDone_q;
   assign err_id       = errId_q;
   assign err_timeout  = errTimeout_q;

endmodule

// File: tb/tb_bmm150_reader.sv
// Testbench for bmm150_reader: a behavioural SPI master/register-file model answers transactions,
// and each scenario task checks the sequencer's observable behaviour against arithmetic expectations.
module tb_bmm150_reader;

   localparam int CLK_HZ      = 1_000_000;
   localparam int STARTUP_US  = 10;
   localparam int SAMPLE_HZ   = 10000;
   localparam int TXN_TIMEOUT = 4096;
   localparam int STARTUP_CYC = 10;
   localparam int PERIOD_CYC  = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b1;
   logic        spi_start, spi_rw;
   logic [6:0]  spi_reg_addr;
   logic [7:0]  spi_tx_data;
   logic [7:0]  spi_rx_data = 8'h00;
   logic        spi_busy = 1'b0;
   logic        spi_done = 1'b0;
   logic [12:0] mag_x, mag_y;
   logic [14:0] mag_z;
   logic [13:0] rhall;
   logic        sample_valid, init_done, err_id, err_timeout;

   bmm150_reader #(
      .CLK_HZ(CLK_HZ), .STARTUP_US(STARTUP_US), .SAMPLE_HZ(SAMPLE_HZ), .TXN_TIMEOUT(TXN_TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .spi_start(spi_start), .spi_rw(spi_rw), .spi_reg_addr(spi_reg_addr), .spi_tx_data(spi_tx_data),
      .spi_rx_data(spi_rx_data), .spi_busy(spi_busy), .spi_done(spi_done),
      .mag_x(mag_x), .mag_y(mag_y), .mag_z(mag_z), .rhall(rhall),
      .sample_valid(sample_valid), .init_done(init_done), .err_id(err_id), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   // Sensor register file and fault-injection controls, written only by the stimulus process
   logic [7:0] mem [128];
   bit         suppressOn = 1'b0;
   logic [6:0] suppressAddr = 7'h00;

   // Transaction log, written only by the SPI master model
   int         stCyc[$];
   logic [6:0] stAddr[$];
   bit         stRw[$];
   logic [7:0] stTx[$];
   int         dnCyc[$];
   int         burstStarts[$];
   int         cnt49 = 0;
   int         protoErr = 0;

   // SPI master model: samples start mid-cycle, drives busy/done just after the rising edge
   bit         active = 1'b0;
   bit         suppressNow = 1'b0;
   int         cdown = 0;
   logic [6:0] curAddr = 7'h00;
   bit         curRw = 1'b0;
   always begin
      @(negedge clk);
      if (!rst_n) begin
         stCyc.delete(); stAddr.delete(); stRw.delete(); stTx.delete();
         dnCyc.delete(); burstStarts.delete();
         cnt49 = 0;
         protoErr = 0;
      end else if (spi_start) begin
         if (active) protoErr++;
         active = 1'b1;
         cdown = $urandom_range(1, 5);
         curAddr = spi_reg_addr;
         curRw = spi_rw;
         suppressNow = suppressOn && spi_rw && (spi_reg_addr == suppressAddr);
         stCyc.push_back(cyc); stAddr.push_back(spi_reg_addr);
         stRw.push_back(spi_rw); stTx.push_back(spi_tx_data);
         if (spi_rw && spi_reg_addr == 7'h42) burstStarts.push_back(cyc);
      end else if (active && (spi_reg_addr !== curAddr || spi_rw !== curRw)) begin
         protoErr++;
      end
      @(posedge clk); #1;
      if (!rst_n) begin
         spi_busy = 1'b0; spi_done = 1'b0; active = 1'b0;
      end else if (spi_done) begin
         spi_done = 1'b0; spi_busy = 1'b0; active = 1'b0;
      end else if (active) begin
         spi_busy = 1'b1;
         if (cdown > 1) cdown--;
         else if (!suppressNow) begin
            spi_done = 1'b1;
            spi_rx_data = curRw ? mem[curAddr] : 8'h00;
            dnCyc.push_back(cyc);
            if (curRw && curAddr == 7'h49) cnt49++;
         end
      end
   end

   function automatic int s16(input logic [7:0] hi, input logic [7:0] lo);
      int v;
      v = int'(hi) * 256 + int'(lo);
      if (v >= 32768) v -= 65536;
      return v;
   endfunction

   // Reference sample from the register file: signed fields are the 16-bit words scaled down by 8 or 2
   function automatic logic [54:0] expectedSample();
      int ex, ey, ez, er;
      ex = s16(mem[7'h43], mem[7'h42]) / 8;
      if (s16(mem[7'h43], mem[7'h42]) < 0 && s16(mem[7'h43], mem[7'h42]) % 8 != 0) ex -= 1;
      ey = s16(mem[7'h45], mem[7'h44]) / 8;
      if (s16(mem[7'h45], mem[7'h44]) < 0 && s16(mem[7'h45], mem[7'h44]) % 8 != 0) ey -= 1;
      ez = s16(mem[7'h47], mem[7'h46]) / 2;
      if (s16(mem[7'h47], mem[7'h46]) < 0 && s16(mem[7'h47], mem[7'h46]) % 2 != 0) ez -= 1;
      er = (int'(mem[7'h49]) * 256 + int'(mem[7'h48])) / 4;
      return {13'(ex), 13'(ey), 15'(ez), 14'(er)};
   endfunction

   task automatic fillBurst(input bit ready);
      for (int i = 0; i < 8; i++) mem[7'h42 + 7'(i)] = 8'($urandom_range(0, 255));
      mem[7'h48][0] = ready;
   endtask

   logic [54:0] curV = '0;

   task automatic holdReset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      enable = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic releaseReset();
      @(posedge clk); #2;
      rst_n = 1'b1;
      curV = '0;
   endtask

   task automatic test_reset();
      holdReset();
      checks++;
      if ({mag_x, mag_y, mag_z, rhall} !== 55'd0) begin
         errors++; $display("[TB] FAIL reset_data: got %h expected 0", {mag_x, mag_y, mag_z, rhall});
      end
      checks++;
      if ({sample_valid, init_done, err_id, err_timeout, spi_start, spi_rw, spi_reg_addr, spi_tx_data} !== 20'd0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got %h expected 0",
                  {sample_valid, init_done, err_id, err_timeout, spi_start, spi_rw, spi_reg_addr, spi_tx_data});
      end
      releaseReset();
      @(negedge clk);
      checks++;
      if (spi_start !== 1'b0) begin
         errors++; $display("[TB] FAIL start_on_release: got %b expected 0", spi_start);
      end
   endtask

   task automatic test_init_sequence();
      int initCyc = -1;
      for (int i = 0; i < 300 && initCyc < 0; i++) begin
         @(negedge clk);
         if (init_done) initCyc = cyc;
      end
      checks++;
      if (initCyc < 0 || stCyc.size() < 3 || dnCyc.size() < 3) begin
         errors++; $display("[TB] FAIL init_timeout: got init_done=%b txns=%0d expected 1 and 3", init_done, stCyc.size());
         return;
      end
      checks++;
      if ({stRw[0], stAddr[0], stTx[0]} !== {1'b0, 7'h4B, 8'h01}) begin
         errors++; $display("[TB] FAIL pwr_write: got %h expected %h", {stRw[0], stAddr[0], stTx[0]}, {1'b0, 7'h4B, 8'h01});
      end
      checks++;
      if ({stRw[1], stAddr[1]} !== {1'b1, 7'h40}) begin
         errors++; $display("[TB] FAIL id_read: got %h expected %h", {stRw[1], stAddr[1]}, {1'b1, 7'h40});
      end
      checks++;
      if (stCyc[1] - dnCyc[0] - 1 < STARTUP_CYC) begin
         errors++; $display("[TB] FAIL startup_gap: got %0d expected >= %0d", stCyc[1] - dnCyc[0] - 1, STARTUP_CYC);
      end
      checks++;
      if ({stRw[2], stAddr[2], stTx[2]} !== {1'b0, 7'h4C, 8'h00}) begin
         errors++; $display("[TB] FAIL mode_write: got %h expected %h", {stRw[2], stAddr[2], stTx[2]}, {1'b0, 7'h4C, 8'h00});
      end
      checks++;
      if (initCyc != dnCyc[2] + 1) begin
         errors++; $display("[TB] FAIL init_done_time: got cycle %0d expected %0d", initCyc, dnCyc[2] + 1);
      end
   endtask

   task automatic test_sample_assembly();
      bit got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (sample_valid) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++; $display("[TB] FAIL first_sample: got no pulse expected pulse");
         return;
      end
      checks++;
      if ({mag_x, mag_y, mag_z, rhall} !== {13'h1FFF, 13'h0001, 15'h3FFF, 14'h04BF}) begin
         errors++; $display("[TB] FAIL fixed_sample: got %h expected %h", {mag_x, mag_y, mag_z, rhall},
                            {13'h1FFF, 13'h0001, 15'h3FFF, 14'h04BF});
      end
      curV = {13'h1FFF, 13'h0001, 15'h3FFF, 14'h04BF};
      @(negedge clk);
      checks++;
      if (sample_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL pulse_width: got %b expected 0", sample_valid);
      end
   endtask

   task automatic test_random_samples();
      for (int k = 0; k < 8; k++) begin
         bit ready;
         int n0, nb, pulses, after;
         logic [54:0] seen, expV;
         ready = ($urandom_range(0, 3) != 0) || (k == 0);
         if (k == 1) ready = 1'b0;
         fillBurst(ready);
         expV = expectedSample();
         n0 = cnt49; nb = burstStarts.size(); pulses = 0; after = -1; seen = '0;
         for (int i = 0; i < 400 && after < 3; i++) begin
            @(negedge clk);
            if (sample_valid) begin pulses++; seen = {mag_x, mag_y, mag_z, rhall}; end
            if (after >= 0) after++;
            else if (cnt49 > n0) after = 0;
         end
         checks++;
         if (after < 3) begin
            errors++; $display("[TB] FAIL burst_timeout: got %0d bursts expected %0d", cnt49, n0 + 1);
            return;
         end
         checks++;
         if (pulses != int'(ready)) begin
            errors++; $display("[TB] FAIL pulse_count[%0d]: got %0d expected %0d", k, pulses, int'(ready));
         end
         if (ready) begin
            curV = expV;
            checks++;
            if (seen !== expV) begin
               errors++; $display("[TB] FAIL rand_sample[%0d]: got %h expected %h", k, seen, expV);
            end
         end else begin
            checks++;
            if ({mag_x, mag_y, mag_z, rhall} !== curV) begin
               errors++; $display("[TB] FAIL hold[%0d]: got %h expected %h", k, {mag_x, mag_y, mag_z, rhall}, curV);
            end
         end
         if (burstStarts.size() > nb && nb >= 1) begin
            checks++;
            if (burstStarts[nb] - burstStarts[nb - 1] != PERIOD_CYC) begin
               errors++; $display("[TB] FAIL period[%0d]: got %0d expected %0d", k,
                                  burstStarts[nb] - burstStarts[nb - 1], PERIOD_CYC);
            end
         end
      end
      checks++;
      if (protoErr != 0) begin
         errors++; $display("[TB] FAIL protocol: got %0d violations expected 0", protoErr);
      end
   endtask

   task automatic test_enable_drop();
      bit found = 1'b0;
      bit got = 1'b0;
      bit orderOk = 1'b1;
      int n;
      logic [54:0] expV;
      fillBurst(1'b1);
      expV = expectedSample();
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk);
         if (spi_start && spi_rw && spi_reg_addr == 7'h45) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++; $display("[TB] FAIL byte3_start: got none expected start of 0x45");
         return;
      end
      @(posedge clk); #2;
      enable = 1'b0;
      n = stCyc.size();
      repeat (200) @(negedge clk);
      checks++;
      if (stCyc.size() != n) begin
         errors++; $display("[TB] FAIL start_while_disabled: got %0d starts expected 0", stCyc.size() - n);
      end
      @(posedge clk); #2;
      enable = 1'b1;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (sample_valid) got = 1'b1;
      end
      checks++;
      if (!got || {mag_x, mag_y, mag_z, rhall} !== expV) begin
         errors++; $display("[TB] FAIL resumed_sample: got %h (pulse %b) expected %h", {mag_x, mag_y, mag_z, rhall}, got, expV);
      end
      if (stAddr.size() < n + 4) orderOk = 1'b0;
      else for (int i = 0; i < 4; i++) if (stAddr[n + i] != 7'h46 + 7'(i)) orderOk = 1'b0;
      checks++;
      if (!orderOk) begin
         errors++; $display("[TB] FAIL resume_order: got first resumed addr %h expected 46..49",
                            (stAddr.size() > n) ? stAddr[n] : 7'h00);
      end
   endtask

   task automatic test_timeout();
      int s = -1;
      int errCyc = -1;
      int n;
      holdReset();
      suppressOn = 1'b1;
      suppressAddr = 7'h44;
      releaseReset();
      for (int i = 0; i < 600 && s < 0; i++) begin
         @(negedge clk);
         if (spi_start && spi_rw && spi_reg_addr == 7'h44) s = cyc;
      end
      for (int i = 0; i < 5000 && s >= 0 && errCyc < 0; i++) begin
         @(negedge clk);
         if (err_timeout) errCyc = cyc;
      end
      checks++;
      if (s < 0 || errCyc < 0 || errCyc - s != TXN_TIMEOUT) begin
         errors++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", errCyc - s, TXN_TIMEOUT);
      end
      n = stCyc.size();
      repeat (200) @(negedge clk);
      checks++;
      if (stCyc.size() != n || err_timeout !== 1'b1 || init_done !== 1'b1 || err_id !== 1'b0) begin
         errors++; $display("[TB] FAIL fault_hold: got starts=%0d err_t=%b init=%b err_id=%b expected 0 1 1 0",
                            stCyc.size() - n, err_timeout, init_done, err_id);
      end
      suppressOn = 1'b0;
   endtask

   task automatic test_bad_id();
      bit seen = 1'b0;
      int n;
      holdReset();
      mem[7'h40] = 8'h31;
      releaseReset();
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (err_id) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++; $display("[TB] FAIL err_id: got %b expected 1", err_id);
      end
      n = stCyc.size();
      repeat (1000) @(negedge clk);
      checks++;
      if (stCyc.size() != n || n != 2) begin
         errors++; $display("[TB] FAIL bad_id_quiet: got %0d total starts expected 2", stCyc.size());
      end
      checks++;
      if (init_done !== 1'b0 || err_timeout !== 1'b0) begin
         errors++; $display("[TB] FAIL bad_id_flags: got init=%b err_t=%b expected 0 0", init_done, err_timeout);
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      mem[7'h40] = 8'h32;
      mem[7'h42] = 8'hF8; mem[7'h43] = 8'hFF; mem[7'h44] = 8'h08; mem[7'h45] = 8'h00;
      mem[7'h46] = 8'hFE; mem[7'h47] = 8'h7F; mem[7'h48] = 8'hFD; mem[7'h49] = 8'h12;
      test_reset();
      test_init_sequence();
      test_sample_assembly();
      test_random_samples();
      test_enable_drop();
      test_timeout();
      test_bad_id();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bmm150_reader.md
Name: bmm150_reader

Overview:
- Sequencer directly upstream of the BMM150 SPI master. Sole driver of that master's control interface.
- Powers the sensor up, checks its chip ID and selects normal mode.
- Then periodically burst-reads the eight data registers and publishes signed X/Y/Z/RHALL samples to downstream logic in one atomic update.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency (Hz).
- STARTUP_US, 3000, wait after power-control write before first read (µs); STARTUP_CYC = CLK_HZ/1_000_000*STARTUP_US.
- SAMPLE_HZ, 10, sample burst rate; PERIOD_CYC = CLK_HZ/SAMPLE_HZ.
- TXN_TIMEOUT, 4096, max cycles from spi_start to spi_done before fault.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  run permission; low blocks new SPI transactions and freezes the period timer.
- spi_start  out  1  one-cycle start pulse to SPI master.
- spi_rw  out  1  0=write, 1=read.
- spi_reg_addr  out  7  register address.
- spi_tx_data  out  8  write data.
- spi_rx_data  in  8  read data from master.
- spi_busy  in  1  master transaction in progress.
- spi_done  in  1  master completion strobe.
- mag_x  out  13  signed X raw.
- mag_y  out  13  signed Y raw.
- mag_z  out  15  signed Z raw.
- rhall  out  14  unsigned hall resistance.
- sample_valid  out  1  one-cycle pulse when outputs update.
- init_done  out  1  high once normal mode is set.
- err_id  out  1  sticky: chip ID != 0x32.
- err_timeout  out  1  sticky: transaction timeout.

Behaviour:
- Reset (rst_n low at clk edge):
  - All outputs 0.
  - State = PWR_ON; timers and byte index cleared.
  - Reset mid-transaction abandons it immediately. spi_start is never asserted in the cycle reset is released.
- Transaction sub-protocol, used for every access:
  - ISSUE: wait until enable=1, spi_busy=0 and spi_done=0. Then drive spi_start=1 for exactly one cycle.
  - spi_rw, spi_reg_addr and spi_tx_data are set in that cycle and held stable until done is seen.
  - WAIT_DONE: ignore spi_busy. On first cycle with spi_done=1, capture spi_rx_data (reads) and advance.
  - Timeout counter starts at the spi_start cycle. Reaching TXN_TIMEOUT: set err_timeout, go to FAULT.
- Main FSM:
  - PWR_ON: write 0x4B <- 0x01.
  - PWR_WAIT: count STARTUP_CYC cycles.
  - READ_ID: read 0x40. Result 0x32 goes to SET_MODE; any other value sets err_id and goes to FAULT.
  - SET_MODE: write 0x4C <- 0x00 (normal mode, ODR 10 Hz). On done, init_done=1 and the period timer is cleared.
  - WAIT_PERIOD: leave when the period timer reaches PERIOD_CYC-1, or immediately after the first SET_MODE.
  - BURST: read 0x42..0x49 in ascending order into an 8-byte buffer, index 0..7. Index increments only on spi_done.
  - PUBLISH: one cycle, then back to WAIT_PERIOD.
  - FAULT: absorbing until reset; spi_start stays 0.
- Period timer:
  - Free-runs from the first burst start, modulo PERIOD_CYC, while enable=1.
  - If a burst overruns the period, the next burst starts immediately after PUBLISH. Bursts never overlap.
- Assembly in PUBLISH (b[i] = byte from address 0x42+i):
  - mag_x = {b1, b0[7:3]}; mag_y = {b3, b2[7:3]}; mag_z = {b5, b4[7:1]}; rhall = {b7, b6[7:2]}.
  - Data-ready bit = b6[0]. If 1: all four outputs update in the same cycle and sample_valid=1 for that cycle.
  - If 0: outputs hold, no pulse, burst retried at next period.
- enable low:
  - An in-flight transaction completes and its data is kept.
  - The FSM then stalls in ISSUE (or WAIT_PERIOD) until enable returns. No state or buffer loss.

Test Plan:
- Reset/init (CLK_HZ=1_000_000, STARTUP_US=10, SAMPLE_HZ=10000): model returns 0x32 from 0x40 -> transaction sequence is write 0x4B/0x01, ≥10-cycle gap, read 0x40, write 0x4C/0x00; init_done=1 after the third done.
- Bad ID: model returns 0x31 -> err_id=1, no further spi_start for 1000 cycles, init_done=0.
- Sample assembly: bytes 0x42..0x49 = F8,FF,08,00,FE,7F,FD,12 -> one sample_valid pulse with mag_x=-1 (0x1FFF), mag_y=1, mag_z=0x3FFF, rhall=0x4BF.
- Data not ready: b6=0xFC -> no sample_valid, outputs unchanged, next burst one period later.
- Timeout: model never asserts spi_done on the 3rd burst read -> err_timeout set exactly TXN_TIMEOUT cycles after that spi_start; FSM in FAULT.
- enable drop mid-burst after byte 3, held low 200 cycles -> no spi_start while low; after release, bytes 4..7 read; sample correct.
